// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: pass-through in 1 cycle, or a multi-cycle memory access with upstream stall.
// Accesses stall via stall_out until mem_done; mem_busy holds the request strobe; 15 silent WAIT cycles flag err.
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        XM_memRead,
    input  logic        XM_memWrite,
    input  logic [15:0] XM_aluOut,
    input  logic [15:0] XM_writeData,
    input  logic [1:0]  XM_regSrc,
    input  logic [15:0] mem_dataOut,
    input  logic        mem_busy,
    input  logic        mem_done,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_dataIn,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] MW_readData,
    output logic [15:0] MW_aluOut,
    output logic [1:0]  MW_regSrc,
    output logic        MW_valid,
    output logic        stall_out,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [1:0]  rs_q, rs_d;
    logic [15:0] mw_rdata_q, mw_rdata_d;
    logic [15:0] mw_alu_q, mw_alu_d;
    logic [1:0]  mw_rs_q, mw_rs_d;
    logic        mw_vld_q, mw_vld_d;
    logic        err_q, err_d;

    logic        any_req;
    logic        acc_ok;
    logic        acc_bad;
    logic        timeout;

    assign any_req = XM_memRead | XM_memWrite;
    assign acc_ok  = (XM_memRead ^ XM_memWrite) & ~XM_aluOut[0];
    assign acc_bad = any_req & ~acc_ok;
    // Counter is cleared on WAIT entry, so 14 marks the 15th silent WAIT cycle.
    assign timeout = (cnt_q == 4'd14);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 16'h0000;
            data_q     <= 16'h0000;
            wr_q       <= 1'b0;
            rs_q       <= 2'd0;
            mw_rdata_q <= 16'h0000;
            mw_alu_q   <= 16'h0000;
            mw_rs_q    <= 2'd0;
            mw_vld_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            rs_q       <= rs_d;
            mw_rdata_q <= mw_rdata_d;
            mw_alu_q   <= mw_alu_d;
            mw_rs_q    <= mw_rs_d;
            mw_vld_q   <= mw_vld_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q;
        rs_d       = rs_q;
        mw_rdata_d = mw_rdata_q;
        mw_alu_d   = mw_alu_q;
        mw_rs_d    = mw_rs_q;
        mw_vld_d   = 1'b0;
        err_d      = err_q;
        stall_out  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acc_ok) begin
                    stall_out = 1'b1;
                    addr_d    = XM_aluOut;
                    data_d    = XM_writeData;
                    wr_d      = XM_memWrite;
                    rs_d      = XM_regSrc;
                    state_d   = S_ISSUE;
                end else begin
                    // Malformed requests still retire as plain ALU results.
                    mw_alu_d   = XM_aluOut;
                    mw_rs_d    = XM_regSrc;
                    mw_rdata_d = 16'h0000;
                    mw_vld_d   = 1'b1;
                    if (acc_bad) begin
                        err_d = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                stall_out = 1'b1;
                mem_rd    = ~wr_q;
                mem_wr    = wr_q;
                if (!mem_busy) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'd0;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (mem_done) begin
                    mw_rdata_d = wr_q ? 16'h0000 : mem_dataOut;
                    mw_alu_d   = addr_q;
                    mw_rs_d    = rs_q;
                    mw_vld_d   = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    stall_out = 1'b1;
                    if (timeout) begin
                        err_d      = 1'b1;
                        mw_rdata_d = 16'h0000;
                        mw_alu_d   = addr_q;
                        mw_rs_d    = rs_q;
                        mw_vld_d   = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr    = addr_q;
    assign mem_dataIn  = data_q;
    assign MW_readData = mw_rdata_q;
    assign MW_aluOut   = mw_alu_q;
    assign MW_regSrc   = mw_rs_q;
    assign MW_valid    = mw_vld_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios then random operations, each checked cycle by cycle
// against a per-operation timeline model (request, busy cycles, wait cycles, result cycle).
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        XM_memRead;
    logic        XM_memWrite;
    logic [15:0] XM_aluOut;
    logic [15:0] XM_writeData;
    logic [1:0]  XM_regSrc;
    logic [15:0] mem_dataOut;
    logic        mem_busy;
    logic        mem_done;
    logic [15:0] mem_addr;
    logic [15:0] mem_dataIn;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] MW_readData;
    logic [15:0] MW_aluOut;
    logic [1:0]  MW_regSrc;
    logic        MW_valid;
    logic        stall_out;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Expected MW latch contents for the coming cycle, and sticky error.
    logic        pend_vld;
    logic [15:0] pend_alu;
    logic [1:0]  pend_rs;
    logic [15:0] pend_rdata;
    logic        exp_err;

    mem_stage_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .XM_memRead   (XM_memRead),
        .XM_memWrite  (XM_memWrite),
        .XM_aluOut    (XM_aluOut),
        .XM_writeData (XM_writeData),
        .XM_regSrc    (XM_regSrc),
        .mem_dataOut  (mem_dataOut),
        .mem_busy     (mem_busy),
        .mem_done     (mem_done),
        .mem_addr     (mem_addr),
        .mem_dataIn   (mem_dataIn),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .MW_readData  (MW_readData),
        .MW_aluOut    (MW_aluOut),
        .MW_regSrc    (MW_regSrc),
        .MW_valid     (MW_valid),
        .stall_out    (stall_out),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_mw();
        chk("MW_valid", {15'd0, MW_valid}, {15'd0, pend_vld});
        if (pend_vld) begin
            chk("MW_aluOut", MW_aluOut, pend_alu);
            chk("MW_regSrc", {14'd0, MW_regSrc}, {14'd0, pend_rs});
            chk("MW_readData", MW_readData, pend_rdata);
        end
        chk("err", {15'd0, err}, {15'd0, exp_err});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        XM_memRead   = 1'b0;
        XM_memWrite  = 1'b0;
        XM_aluOut    = 16'h0000;
        XM_writeData = 16'h0000;
        XM_regSrc    = 2'd0;
        mem_busy     = 1'b0;
        mem_done     = 1'b0;
        mem_dataOut  = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst mem_addr", mem_addr, 16'h0000);
        chk("rst mem_dataIn", mem_dataIn, 16'h0000);
        chk("rst mem_rd", {15'd0, mem_rd}, 16'h0000);
        chk("rst mem_wr", {15'd0, mem_wr}, 16'h0000);
        chk("rst MW_readData", MW_readData, 16'h0000);
        chk("rst MW_aluOut", MW_aluOut, 16'h0000);
        chk("rst MW_regSrc", {14'd0, MW_regSrc}, 16'h0000);
        chk("rst MW_valid", {15'd0, MW_valid}, 16'h0000);
        chk("rst stall_out", {15'd0, stall_out}, 16'h0000);
        chk("rst err", {15'd0, err}, 16'h0000);
        // This idle cycle with zero inputs retires as a pass-through.
        pend_vld   = 1'b1;
        pend_alu   = 16'h0000;
        pend_rs    = 2'd0;
        pend_rdata = 16'h0000;
        exp_err    = 1'b0;
    endtask

    // One operation: request at cycle 0, busy_n refused cycles, done on WAIT cycle done_at
    // (done_at >= 15 means never). abort_k stops the operation before that cycle.
    task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, input logic [1:0] rs, input int busy_n,
                         input int done_at, input logic [15:0] rdata, input int abort_k);
        bit legal;
        bit illegal;
        bit tmo;
        bit strobe;
        int last;
        int wait0;
        legal   = (rd ^ wr) && !addr[0];
        illegal = (rd || wr) && !legal;
        tmo     = legal && (done_at >= 15);
        wait0   = busy_n + 2;
        last    = !legal ? 0 : (tmo ? wait0 + 14 : wait0 + done_at);
        for (int k = 0; k <= last; k++) begin
            if (k == abort_k) return;
            @(posedge clk);
            #1;
            XM_memRead   = rd;
            XM_memWrite  = wr;
            XM_aluOut    = addr;
            XM_writeData = data;
            XM_regSrc    = rs;
            if (legal && k >= 1 && k <= busy_n)
                mem_busy = 1'b1;
            else if (legal && k == busy_n + 1)
                mem_busy = 1'b0;
            else
                mem_busy = 1'($urandom);
            if (legal && k >= wait0)
                mem_done = (k == last) && !tmo;
            else
                mem_done = 1'($urandom);
            mem_dataOut = (legal && k == last && !tmo) ? rdata : 16'($urandom);
            @(negedge clk);
            strobe = legal && k >= 1 && k <= busy_n + 1;
            chk("stall_out", {15'd0, stall_out}, {15'd0, legal && (k < last || tmo)});
            chk("mem_rd", {15'd0, mem_rd}, {15'd0, strobe && rd});
            chk("mem_wr", {15'd0, mem_wr}, {15'd0, strobe && wr});
            if (strobe) begin
                chk("mem_addr", mem_addr, addr);
                chk("mem_dataIn", mem_dataIn, data);
            end
            chk_mw();
            if (k == last) begin
                pend_vld   = 1'b1;
                pend_alu   = addr;
                pend_rs    = rs;
                pend_rdata = (legal && rd && !tmo) ? rdata : 16'h0000;
                exp_err    = exp_err | illegal | tmo;
            end else begin
                pend_vld = 1'b0;
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        XM_memRead   = 1'b0;
        XM_memWrite  = 1'b0;
        XM_aluOut    = 16'h0000;
        XM_writeData = 16'h0000;
        XM_regSrc    = 2'd0;
        mem_dataOut  = 16'h0000;
        mem_busy     = 1'b0;
        mem_done     = 1'b0;
        pend_vld     = 1'b0;
        pend_alu     = 16'h0000;
        pend_rs      = 2'd0;
        pend_rdata   = 16'h0000;
        exp_err      = 1'b0;

        do_reset();
        // ALU pass-through, then a read completing on the 2nd WAIT cycle.
        do_op(1'b0, 1'b0, 16'h1234, 16'h0000, 2'd2, 0, 0, 16'h0000, -1);
        do_op(1'b1, 1'b0, 16'h0040, 16'h0000, 2'd1, 0, 1, 16'hBEEF, -1);
        // Write refused three times before acceptance.
        do_op(1'b0, 1'b1, 16'h0010, 16'hA5A5, 2'd0, 3, 2, 16'h0000, -1);
        do_op(1'b0, 1'b0, 16'h0777, 16'h0000, 2'd3, 0, 0, 16'h0000, -1);
        // Reset while waiting, then a normal access.
        do_op(1'b1, 1'b0, 16'h0080, 16'h0000, 2'd1, 0, 6, 16'h1111, 3);
        do_reset();
        do_op(1'b1, 1'b0, 16'h00A0, 16'h0000, 2'd1, 1, 0, 16'h5A5A, -1);
        // Read that never completes.
        do_op(1'b1, 1'b0, 16'h0200, 16'h0000, 2'd1, 0, 99, 16'h0000, -1);
        do_op(1'b0, 1'b0, 16'h0001, 16'h0000, 2'd0, 0, 0, 16'h0000, -1);
        do_reset();
        // Odd address, then both strobes requested.
        do_op(1'b1, 1'b0, 16'h0003, 16'h0000, 2'd1, 0, 0, 16'h0000, -1);
        do_op(1'b1, 1'b1, 16'h0010, 16'h1234, 2'd2, 0, 0, 16'h0000, -1);
        do_op(1'b1, 1'b0, 16'h0020, 16'h0000, 2'd1, 0, 0, 16'hCAFE, -1);
        do_reset();

        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic        rd;
            logic        wr;
            logic [15:0] a;
            kind = $urandom_range(0, 9);
            a    = 16'($urandom);
            rd   = 1'b0;
            wr   = 1'b0;
            if (kind >= 2 && kind <= 5) begin
                rd = 1'b1;
                a[0] = 1'b0;
            end else if (kind >= 6 && kind <= 8) begin
                wr = 1'b1;
                a[0] = 1'b0;
            end else if (kind == 9) begin
                rd = 1'($urandom);
                wr = ~rd | 1'($urandom);
                if (rd ^ wr) a[0] = 1'b1;
            end
            do_op(rd, wr, a, 16'($urandom), 2'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5), 16'($urandom), -1);
        end
        do_op(1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 0, 0, 16'h0000, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
